// File: rtl/voice_allocator_pkg.sv
// Shared constants and FSM encoding for the voice allocator slice.
package voice_allocator_pkg;

  localparam int DEF_NUM_VOICES = 4;
  localparam int DEF_NOTE_W     = 5;
  localparam int DEF_AGE_W      = 4;

  // Note code 0 is reserved: a voice holding it is silent.
  localparam logic [DEF_NOTE_W-1:0] NOTE_SILENCE = '0;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SEARCH = 1'b1
  } state_t;

endpackage

// File: rtl/voice_allocator_if.sv
// Note-event handshake between key decode (master) and the voice allocator (slave).
interface voice_allocator_if #(
  parameter int NOTE_W = voice_allocator_pkg::DEF_NOTE_W
);

  logic              ev_valid;
  logic              ev_ready;
  logic              ev_on;
  logic [NOTE_W-1:0] ev_note;

  modport master (
    output ev_valid,
    output ev_on,
    output ev_note,
    input  ev_ready
  );

  modport slave (
    input  ev_valid,
    input  ev_on,
    input  ev_note,
    output ev_ready
  );

endinterface

// File: rtl/voice_select.sv
// Combinational voice lookup: note match, lowest free voice and steal victim.
module voice_select
  import voice_allocator_pkg::*;
#(
  parameter int NUM_VOICES = DEF_NUM_VOICES,
  parameter int NOTE_W     = DEF_NOTE_W,
  parameter int AGE_W      = DEF_AGE_W,
  parameter int IDX_W      = $clog2(NUM_VOICES)
) (
  input  logic [NUM_VOICES-1:0][NOTE_W-1:0] notes,
  input  logic [NUM_VOICES-1:0]             active,
  input  logic [NUM_VOICES-1:0]             held,
  input  logic [NUM_VOICES-1:0][AGE_W-1:0]  ages,
  input  logic [NOTE_W-1:0]                 ev_note,
  output logic                              match_hit,
  output logic [IDX_W-1:0]                  match_idx,
  output logic                              free_hit,
  output logic [IDX_W-1:0]                  free_idx,
  output logic [IDX_W-1:0]                  victim_idx
);

  logic             any_held;
  logic             victim_found;
  logic [AGE_W-1:0] best_age;

  // NOTE: combinational blocks use blocking '=' and give every output a default
  // first, so no path leaves a variable unassigned (which would infer a latch).
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    free_hit  = 1'b0;
    free_idx  = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (!match_hit && active[i] && (notes[i] == ev_note)) begin
        match_hit = 1'b1;
        match_idx = IDX_W'(i);
      end
      if (!free_hit && !active[i]) begin
        free_hit = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  // Held voices are sacrificed before any still-keyed voice; strict '>' keeps
  // the lowest index on an age tie.
  always_comb begin
    any_held     = |held;
    victim_found = 1'b0;
    best_age     = '0;
    victim_idx   = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if ((!any_held || held[i]) && (!victim_found || (ages[i] > best_age))) begin
        victim_found = 1'b1;
        best_age     = ages[i];
        victim_idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Assigns note events to tone-generator voices with retrigger, free-slot and
// steal policies, plus sustain-pedal hold and release.
module voice_allocator
  import voice_allocator_pkg::*;
#(
  parameter int NUM_VOICES = DEF_NUM_VOICES,
  parameter int NOTE_W     = DEF_NOTE_W,
  parameter int AGE_W      = DEF_AGE_W
) (
  input  logic                         clock,
  input  logic                         reset,
  voice_allocator_if.slave             ev,
  input  logic                         sustain,
  output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
  output logic [NUM_VOICES-1:0]        voice_active,
  output logic [NUM_VOICES-1:0]        voice_held,
  output logic                         steal
);

  localparam int               IDX_W   = $clog2(NUM_VOICES);
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  state_t                            state;
  logic                              ready_q;
  logic                              on_q;
  logic [NOTE_W-1:0]                 note_q;
  logic                              sus_q;
  logic                              sus_prev;
  logic [NUM_VOICES-1:0][NOTE_W-1:0] notes;
  logic [NUM_VOICES-1:0]             active;
  logic [NUM_VOICES-1:0]             held;
  logic [NUM_VOICES-1:0][AGE_W-1:0]  ages;
  logic                              steal_q;

  logic                              match_hit;
  logic [IDX_W-1:0]                  match_idx;
  logic                              free_hit;
  logic [IDX_W-1:0]                  free_idx;
  logic [IDX_W-1:0]                  victim_idx;

  logic [NUM_VOICES-1:0][NOTE_W-1:0] n_notes;
  logic [NUM_VOICES-1:0]             n_active;
  logic [NUM_VOICES-1:0]             n_held;
  logic [NUM_VOICES-1:0][AGE_W-1:0]  n_ages;
  logic                              n_steal;
  logic [IDX_W-1:0]                  wr_idx;
  logic                              release_edge;

  voice_select #(
    .NUM_VOICES (NUM_VOICES),
    .NOTE_W     (NOTE_W),
    .AGE_W      (AGE_W),
    .IDX_W      (IDX_W)
  ) u_select (
    .notes      (notes),
    .active     (active),
    .held       (held),
    .ages       (ages),
    .ev_note    (note_q),
    .match_hit  (match_hit),
    .match_idx  (match_idx),
    .free_hit   (free_hit),
    .free_idx   (free_idx),
    .victim_idx (victim_idx)
  );

  assign release_edge = sus_prev & ~sustain;

  // Commit of the pending event first, then the pedal release, so a note-off
  // held in the release cycle is still freed.
  always_comb begin
    n_notes  = notes;
    n_active = active;
    n_held   = held;
    n_ages   = ages;
    n_steal  = 1'b0;
    wr_idx   = '0;

    if ((state == ST_SEARCH) && (note_q != NOTE_W'(NOTE_SILENCE))) begin
      if (on_q) begin
        if (match_hit) begin
          wr_idx = match_idx;
        end else if (free_hit) begin
          wr_idx = free_idx;
        end else begin
          wr_idx  = victim_idx;
          n_steal = 1'b1;
        end
        n_notes[wr_idx]  = note_q;
        n_active[wr_idx] = 1'b1;
        n_held[wr_idx]   = 1'b0;
        n_ages[wr_idx]   = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (active[i] && (IDX_W'(i) != wr_idx) && (ages[i] != AGE_MAX)) begin
            n_ages[i] = ages[i] + 1'b1;
          end
        end
      end else if (match_hit) begin
        if (sus_q) begin
          n_held[match_idx] = 1'b1;
        end else begin
          n_notes[match_idx]  = NOTE_W'(NOTE_SILENCE);
          n_active[match_idx] = 1'b0;
          n_held[match_idx]   = 1'b0;
          n_ages[match_idx]   = '0;
        end
      end
    end

    if (release_edge) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (n_held[i]) begin
          n_notes[i]  = NOTE_W'(NOTE_SILENCE);
          n_active[i] = 1'b0;
          n_held[i]   = 1'b0;
          n_ages[i]   = '0;
        end
      end
    end
  end

  // NOTE: all state is in flops (no RAM), so every register is reset and
  // written only with non-blocking '<=' to avoid ordering races between blocks.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      ready_q  <= 1'b1;
      on_q     <= 1'b0;
      note_q   <= '0;
      sus_q    <= 1'b0;
      sus_prev <= 1'b0;
      notes    <= '0;
      active   <= '0;
      held     <= '0;
      ages     <= '0;
      steal_q  <= 1'b0;
    end else begin
      sus_prev <= sustain;
      notes    <= n_notes;
      active   <= n_active;
      held     <= n_held;
      ages     <= n_ages;
      steal_q  <= n_steal;
      case (state)
        ST_IDLE: begin
          if (ev.ev_valid && ready_q) begin
            on_q    <= ev.ev_on;
            note_q  <= ev.ev_note;
            sus_q   <= sustain;
            ready_q <= 1'b0;
            state   <= ST_SEARCH;
          end
        end
        ST_SEARCH: begin
          ready_q <= 1'b1;
          state   <= ST_IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign ev.ev_ready   = ready_q;
  assign voice_note    = notes;
  assign voice_active  = active;
  assign voice_held    = held;
  assign steal         = steal_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: event table plus sustain/handshake/reset sequences.
module tb_voice_allocator;

  localparam int NV = 4;
  localparam int NW = 5;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              sustain = 1'b0;
  logic [NV*NW-1:0]  voice_note;
  logic [NV-1:0]     voice_active;
  logic [NV-1:0]     voice_held;
  logic              steal;

  int n_checks = 0;
  int n_fail   = 0;

  voice_allocator_if #(.NOTE_W(NW)) ev_if ();

  voice_allocator #(
    .NUM_VOICES (NV),
    .NOTE_W     (NW),
    .AGE_W      (4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .ev           (ev_if),
    .sustain      (sustain),
    .voice_note   (voice_note),
    .voice_active (voice_active),
    .voice_held   (voice_held),
    .steal        (steal)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, need finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic              on;
    logic [NW-1:0]     note;
    logic [NV*NW-1:0]  notes;
    logic [NV-1:0]     active;
    logic [NV-1:0]     held;
    logic              stl;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [NV*NW-1:0] en,
                             input logic [NV-1:0] ea, input logic [NV-1:0] eh,
                             input logic es);
    check({tag, ".note"},   32'(voice_note),   32'(en));
    check({tag, ".active"}, 32'(voice_active), 32'(ea));
    check({tag, ".held"},   32'(voice_held),   32'(eh));
    check({tag, ".steal"},  32'(steal),        32'(es));
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    sustain = 1'b0;
    ev_if.ev_valid = 1'b0;
    ev_if.ev_on = 1'b0;
    ev_if.ev_note = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Offer one event from IDLE; returns 1 time unit after the committing edge.
  task automatic send(input logic on, input logic [NW-1:0] note);
    @(negedge clock);
    ev_if.ev_valid = 1'b1;
    ev_if.ev_on = on;
    ev_if.ev_note = note;
    @(posedge clock);
    #1;
    ev_if.ev_valid = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic set_sustain(input logic v);
    @(negedge clock);
    sustain = v;
  endtask

  initial begin
    ev_if.ev_valid = 1'b0;
    ev_if.ev_on = 1'b0;
    ev_if.ev_note = '0;

    // notes packed as {v3, v2, v1, v0}
    vecs[0]  = '{1'b1, 5'd5,  {5'd0,  5'd0, 5'd0, 5'd5},  4'b0001, 4'b0000, 1'b0};
    vecs[1]  = '{1'b1, 5'd7,  {5'd0,  5'd0, 5'd7, 5'd5},  4'b0011, 4'b0000, 1'b0};
    vecs[2]  = '{1'b1, 5'd5,  {5'd0,  5'd0, 5'd7, 5'd5},  4'b0011, 4'b0000, 1'b0};
    vecs[3]  = '{1'b1, 5'd0,  {5'd0,  5'd0, 5'd7, 5'd5},  4'b0011, 4'b0000, 1'b0};
    vecs[4]  = '{1'b0, 5'd8,  {5'd0,  5'd0, 5'd7, 5'd5},  4'b0011, 4'b0000, 1'b0};
    vecs[5]  = '{1'b1, 5'd3,  {5'd0,  5'd3, 5'd7, 5'd5},  4'b0111, 4'b0000, 1'b0};
    vecs[6]  = '{1'b1, 5'd4,  {5'd4,  5'd3, 5'd7, 5'd5},  4'b1111, 4'b0000, 1'b0};
    vecs[7]  = '{1'b1, 5'd9,  {5'd4,  5'd3, 5'd9, 5'd5},  4'b1111, 4'b0000, 1'b1};
    vecs[8]  = '{1'b0, 5'd3,  {5'd4,  5'd0, 5'd9, 5'd5},  4'b1011, 4'b0000, 1'b0};
    vecs[9]  = '{1'b1, 5'd6,  {5'd4,  5'd6, 5'd9, 5'd5},  4'b1111, 4'b0000, 1'b0};
    vecs[10] = '{1'b1, 5'd11, {5'd4,  5'd6, 5'd9, 5'd11}, 4'b1111, 4'b0000, 1'b1};
    vecs[11] = '{1'b1, 5'd12, {5'd12, 5'd6, 5'd9, 5'd11}, 4'b1111, 4'b0000, 1'b1};

    // Reset state
    do_reset();
    check("reset.ready", 32'(ev_if.ev_ready), 32'd1);
    check_state("reset", '0, 4'b0000, 4'b0000, 1'b0);

    // Event table: retrigger, ignored note 0, absent note-off, fill, steals by age
    foreach (vecs[i]) begin
      send(vecs[i].on, vecs[i].note);
      check_state($sformatf("vec%0d", i), vecs[i].notes, vecs[i].active,
                  vecs[i].held, vecs[i].stl);
    end

    // Fill 3,4,5,6 then steal oldest voice0; steal lasts one cycle
    do_reset();
    send(1'b1, 5'd3); send(1'b1, 5'd4); send(1'b1, 5'd5); send(1'b1, 5'd6);
    send(1'b1, 5'd9);
    check_state("steal_oldest", {5'd6, 5'd5, 5'd4, 5'd9}, 4'b1111, 4'b0000, 1'b1);
    @(posedge clock); #1;
    check("steal_pulse_end", 32'(steal), 32'd0);

    // Sustain hold then release on pedal falling edge
    do_reset();
    set_sustain(1'b1);
    send(1'b1, 5'd3);
    send(1'b0, 5'd3);
    check_state("sus_held", {15'd0, 5'd3}, 4'b0001, 4'b0001, 1'b0);
    set_sustain(1'b0);
    @(posedge clock); #1;
    check_state("sus_release", '0, 4'b0000, 4'b0000, 1'b0);

    // Held voice is the steal victim ahead of the older keyed voice0
    do_reset();
    send(1'b1, 5'd3); send(1'b1, 5'd4); send(1'b1, 5'd5); send(1'b1, 5'd6);
    set_sustain(1'b1);
    send(1'b0, 5'd5);
    check_state("held_mark", {5'd6, 5'd5, 5'd4, 5'd3}, 4'b1111, 4'b0100, 1'b0);
    send(1'b1, 5'd9);
    check_state("steal_held", {5'd6, 5'd9, 5'd4, 5'd3}, 4'b1111, 4'b0000, 1'b1);

    // Note-off committed with sus_q=1 in the release cycle is freed
    do_reset();
    set_sustain(1'b1);
    send(1'b1, 5'd3);
    @(negedge clock);
    ev_if.ev_valid = 1'b1; ev_if.ev_on = 1'b0; ev_if.ev_note = 5'd3;
    @(posedge clock); #1;
    ev_if.ev_valid = 1'b0;
    @(negedge clock);
    sustain = 1'b0;
    @(posedge clock); #1;
    check_state("off_at_release", '0, 4'b0000, 4'b0000, 1'b0);

    // Note-on to a held voice in the release cycle keeps it alive
    do_reset();
    set_sustain(1'b1);
    send(1'b1, 5'd3);
    send(1'b0, 5'd3);
    @(negedge clock);
    ev_if.ev_valid = 1'b1; ev_if.ev_on = 1'b1; ev_if.ev_note = 5'd3;
    @(posedge clock); #1;
    ev_if.ev_valid = 1'b0;
    @(negedge clock);
    sustain = 1'b0;
    @(posedge clock); #1;
    check_state("on_at_release", {15'd0, 5'd3}, 4'b0001, 4'b0000, 1'b0);

    // ev_valid held 3 cycles: ready 1,0,1; then reset during SEARCH drops event
    do_reset();
    @(negedge clock);
    ev_if.ev_valid = 1'b1; ev_if.ev_on = 1'b1; ev_if.ev_note = 5'd5;
    check("hs.ready0", 32'(ev_if.ev_ready), 32'd1);
    @(negedge clock);
    check("hs.ready1", 32'(ev_if.ev_ready), 32'd0);
    @(negedge clock);
    check("hs.ready2", 32'(ev_if.ev_ready), 32'd1);
    check("hs.first_commit", 32'(voice_note), 32'd5);
    ev_if.ev_note = 5'd7;
    @(negedge clock);
    check("hs.ready3", 32'(ev_if.ev_ready), 32'd0);
    ev_if.ev_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("rst_search.ready", 32'(ev_if.ev_ready), 32'd1);
    check_state("rst_search", '0, 4'b0000, 4'b0000, 1'b0);
    @(posedge clock); #1;
    check_state("rst_search_after", '0, 4'b0000, 4'b0000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
